// File: rtl/chip8_mem_arbiter_if.sv
// Bus between the three CHIP-8 RAM requesters (ld, cpu, gfx), the arbiter and the RAM macro.
// master = requesters + RAM side, slave = arbiter.
interface chip8_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              ld_req,  cpu_req,  gfx_req;
    logic              ld_we,   cpu_we,   gfx_we;
    logic [ADDR_W-1:0] ld_addr, cpu_addr, gfx_addr;
    logic [DATA_W-1:0] ld_wdata, cpu_wdata, gfx_wdata;
    logic              ld_gnt,  cpu_gnt,  gfx_gnt;
    logic              ld_rvalid, cpu_rvalid, gfx_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re, mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    modport master (
        output ld_req, cpu_req, gfx_req, ld_we, cpu_we, gfx_we,
               ld_addr, cpu_addr, gfx_addr, ld_wdata, cpu_wdata, gfx_wdata, mem_rdata,
        input  ld_gnt, cpu_gnt, gfx_gnt, ld_rvalid, cpu_rvalid, gfx_rvalid, rdata,
               mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  ld_req, cpu_req, gfx_req, ld_we, cpu_we, gfx_we,
               ld_addr, cpu_addr, gfx_addr, ld_wdata, cpu_wdata, gfx_wdata, mem_rdata,
        output ld_gnt, cpu_gnt, gfx_gnt, ld_rvalid, cpu_rvalid, gfx_rvalid, rdata,
               mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Single-port CHIP-8 RAM arbiter: one owner at a time, bounded bursts, tagged 1-cycle read return.
// Define CHIP8_ARB_RR_EN for round-robin arbitration; default is fixed priority ld > gfx > cpu.
module chip8_mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input logic               clk,
    input logic               reset,
    chip8_mem_arbiter_if.slave bus
);
    localparam int         NUM_REQ = 3;
    localparam logic [1:0] LD  = 2'd0;
    localparam logic [1:0] CPU = 2'd1;
    localparam logic [1:0] GFX = 2'd2;

    typedef enum logic {IDLE, OWN} state_t;

    state_t                            state_q, state_d;
    logic [1:0]                        owner_q, owner_d, win;
    logic [7:0]                        beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0]                gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [NUM_REQ-1:0]                req, we;
    logic [NUM_REQ-1:0][ADDR_W-1:0]    addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]    wdata;
    logic                              active, beat, rd_beat, wr_beat;

    assign req   = {bus.gfx_req, bus.cpu_req, bus.ld_req};
    // gfx is read-only: its write enable never reaches the RAM
    assign we    = {bus.gfx_we & 1'b0, bus.cpu_we, bus.ld_we};
    assign addr  = {bus.gfx_addr, bus.cpu_addr, bus.ld_addr};
    assign wdata = {bus.gfx_wdata, bus.cpu_wdata, bus.ld_wdata};

    // Reset gates the outputs immediately, so a beat issued just before reset never returns data.
    assign active  = ~reset;
    assign beat    = active && (state_q == OWN) && req[owner_q];
    assign rd_beat = beat && !we[owner_q];
    assign wr_beat = beat &&  we[owner_q];

`ifdef CHIP8_ARB_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        logic       found;
        logic [1:0] idx;
        win   = LD;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && |req)
            rr_ptr_d = (win == GFX) ? LD : win + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= LD;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        if (req[LD])       win = LD;
        else if (req[GFX]) win = GFX;
        else               win = CPU;
    end
`endif

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        beat_cnt_d        = beat_cnt_q;
        gnt_d             = gnt_q;
        rvalid_d          = '0;
        rvalid_d[owner_q] = rd_beat;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    owner_d    = win;
                    beat_cnt_d = '0;
                    gnt_d      = NUM_REQ'(1) << win;
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
                    if ({1'b0, beat_cnt_q} + 9'd1 == 9'(MAX_BURST)) begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= LD;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign bus.ld_gnt     = gnt_q[LD]  & active;
    assign bus.cpu_gnt    = gnt_q[CPU] & active;
    assign bus.gfx_gnt    = gnt_q[GFX] & active;
    assign bus.ld_rvalid  = rvalid_q[LD]  & active;
    assign bus.cpu_rvalid = rvalid_q[CPU] & active;
    assign bus.gfx_rvalid = rvalid_q[GFX] & active;
    assign bus.rdata      = (active && |rvalid_q) ? bus.mem_rdata : '0;

    assign bus.mem_addr  = beat    ? addr[owner_q]  : '0;
    assign bus.mem_wdata = wr_beat ? wdata[owner_q] : '0;
    assign bus.mem_re    = rd_beat;
    assign bus.mem_we    = wr_beat;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Randomized scoreboard bench for chip8_mem_arbiter: shadow-RAM reference plus per-cycle
// arbitration rules (grant latency, priority, burst limit, idle gap).
module tb_chip8_mem_arbiter;
    localparam int MAXB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_init = 1'b1;
    always #5 clk = ~clk;

    chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [2:0]  req = '0;
    logic [2:0]  we  = '0;
    logic [11:0] addr  [3];
    logic [7:0]  wdata [3];
    logic [7:0]  ram [4096];
    logic [7:0]  shadow [4096];
    logic [7:0]  mem_rdata_r;

    assign bus.ld_req = req[0];  assign bus.cpu_req = req[1];  assign bus.gfx_req = req[2];
    assign bus.ld_we  = we[0];   assign bus.cpu_we  = we[1];   assign bus.gfx_we  = we[2];
    assign bus.ld_addr  = addr[0];  assign bus.cpu_addr  = addr[1];  assign bus.gfx_addr  = addr[2];
    assign bus.ld_wdata = wdata[0]; assign bus.cpu_wdata = wdata[1]; assign bus.gfx_wdata = wdata[2];
    assign bus.mem_rdata = mem_rdata_r;

    wire [2:0] gnt = {bus.gfx_gnt, bus.cpu_gnt, bus.ld_gnt};
    wire [2:0] rv  = {bus.gfx_rvalid, bus.cpu_rvalid, bus.ld_rvalid};

    function automatic logic [7:0] ram_f(input logic [11:0] a);
        return a[7:0] ^ 8'hA2;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= ram_f(12'(i));
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_re) mem_rdata_r <= ram[bus.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req_v);
        tests++;
        if (got !== req_v) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req_v, cyc);
        end
    endtask

    typedef struct { int idx; logic [7:0] d; } exp_t;
    exp_t exp_q[$];

    int first_beat [3];
    int last_beat  [3];
    int start_cyc  [3];
    int gfx_beats[$];
    logic [7:0] last_cpu_rdata;

    // Requester driver: holds req, advances to the next beat after each accepted one.
    task automatic burst(input int idx, input int len, input bit w, input logic [11:0] base,
                         input logic [7:0] d0);
        int n;
        n = 0;
        @(posedge clk); #1;
        req[idx] = 1'b1; we[idx] = w; addr[idx] = base; wdata[idx] = d0;
        start_cyc[idx] = cyc;
        while (n < len) begin
            @(negedge clk);
            if (gnt[idx]) begin
                if (w && idx != 2) shadow[addr[idx]] = wdata[idx];
                else exp_q.push_back('{idx: idx, d: shadow[addr[idx]]});
                if (n == 0) first_beat[idx] = cyc;
                last_beat[idx] = cyc;
                if (idx == 2) gfx_beats.push_back(cyc);
                n++;
            end
            if (n < len && cyc - start_cyc[idx] > 3000) begin
                check("burst_timeout", 32'(n), 32'(len));
                n = len;
            end
            @(posedge clk); #1;
            if (n < len) begin
                addr[idx]  = base + 12'(n);
                wdata[idx] = d0 + 8'(n * 8'h22);
            end else begin
                req[idx] = 1'b0;
            end
        end
    endtask

    function automatic logic [2:0] pick(input logic [2:0] r, input int p);
`ifdef CHIP8_ARB_RR_EN
        for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return 3'(1) << ((p + k) % 3);
        return 3'b000;
`else
        if (p < 0)  return 3'b000;
        if (r[0])   return 3'b001;
        if (r[2])   return 3'b100;
        if (r[1])   return 3'b010;
        return 3'b000;
`endif
    endfunction

    // Monitor: scoreboard for read returns plus the arbitration rules, every cycle.
    initial begin
        logic [2:0] prev_gnt, prev_req, exp_g;
        logic       prev_ok, bt, e_re, e_we;
        logic [11:0] e_addr;
        int win, ptr, o;
        exp_t e;
        prev_ok = 0; win = 0; ptr = 0; prev_gnt = '0; prev_req = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_ok = 0; win = 0; ptr = 0;
            end else begin
                if (|rv) begin
                    if (exp_q.size() == 0) begin
                        check("rvalid_unexpected", {29'd0, rv}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rvalid_tag", {29'd0, rv}, 32'(3'(1) << e.idx));
                        check("rdata", {24'd0, bus.rdata}, {24'd0, e.d});
                        if (e.idx == 1) last_cpu_rdata = bus.rdata;
                    end
                end
                check("gnt_onehot_re_we_excl",
                      {30'd0, $onehot0(gnt), bus.mem_re & bus.mem_we}, 32'b10);
                if (prev_ok) begin
                    if (prev_gnt == 0)                                exp_g = pick(prev_req, ptr);
                    else if (!(|(prev_gnt & prev_req)) || win == MAXB) exp_g = 3'b000;
                    else                                              exp_g = prev_gnt;
                    check("gnt_rule", {29'd0, gnt}, {29'd0, exp_g});
                    if (prev_gnt == 0 && gnt != 0)
                        ptr = gnt[0] ? 1 : gnt[1] ? 2 : 0;
                end
                o = gnt[2] ? 2 : gnt[1] ? 1 : 0;
                bt = |(gnt & req);
                e_re = bt && !(o != 2 && we[o]);
                e_we = bt && (o != 2) && we[o];
                e_addr = bt ? addr[o] : 12'd0;
                check("mem_strobes_addr", {18'd0, e_addr == bus.mem_addr, bus.mem_re, bus.mem_we, 11'd0},
                      {18'd0, 1'b1, e_re, e_we, 11'd0});
                win = (gnt == 0) ? 0 : win + int'(bt);
                prev_gnt = gnt; prev_req = req; prev_ok = 1;
            end
        end
    end

    task automatic rand_thread(input int idx);
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            burst(idx, $urandom_range(1, 20), (idx != 2) && ($urandom_range(0, 1) == 1),
                  12'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
        for (int i = 0; i < 4096; i++) shadow[i] = ram_f(12'(i));
        repeat (2) @(posedge clk);
        #1 ram_init = 1'b0;
        @(negedge clk);
        check("reset_outputs", {gnt, rv, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata},
              32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {29'd0, gnt}, 32'd0);

        // single cpu read of 0x200
        burst(1, 1, 1'b0, 12'h200, 8'h00);
        check("cpu_grant_latency", 32'(first_beat[1] - start_cyc[1]), 32'd1);
        @(negedge clk);
        check("cpu_rdata_a2", {24'd0, last_cpu_rdata}, 32'h0A2);

        // ld writes 4 bytes, cpu reads them back
        burst(0, 4, 1'b1, 12'h200, 8'h12);
        check("ld_write_beats", 32'(last_beat[0] - first_beat[0]), 32'd3);
        burst(1, 4, 1'b0, 12'h200, 8'h00);
        @(negedge clk);
        check("cpu_readback_last", {24'd0, last_cpu_rdata}, 32'h078);

        // gfx and cpu contend in the same cycle
        fork
            burst(2, 3, 1'b0, 12'h400, 8'h00);
            burst(1, 3, 1'b0, 12'h500, 8'h00);
        join
`ifndef CHIP8_ARB_RR_EN
        check("gfx_wins", 32'(first_beat[2] - start_cyc[2]), 32'd1);
        check("cpu_after_gfx", 32'(first_beat[1] - last_beat[2]), 32'd3);
`endif

        // 20-beat gfx burst split at MAX_BURST
        gfx_beats.delete();
        burst(2, 20, 1'b0, 12'h300, 8'h00);
        check("gfx20_count", 32'(gfx_beats.size()), 32'd20);
        if (gfx_beats.size() == 20) begin
            check("gfx20_first16", 32'(gfx_beats[15] - gfx_beats[0]), 32'd15);
            check("gfx20_gap", 32'(gfx_beats[16] - gfx_beats[15]), 32'd2);
            check("gfx20_tail", 32'(gfx_beats[19] - gfx_beats[16]), 32'd3);
        end

        // reset right after a cpu read beat
        burst(1, 1, 1'b0, 12'h210, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("reset_rvalid_suppressed", {29'd0, rv}, 32'd0);
        check("reset_gnt_low", {29'd0, gnt}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        burst(1, 1, 1'b0, 12'h200, 8'h00);
        check("post_reset_latency", 32'(first_beat[1] - start_cyc[1]), 32'd1);

        // randomized contention
        fork
            rand_thread(0);
            rand_thread(1);
            rand_thread(2);
        join
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
